fifo_stream_reader: RTL and testbench

Read-side master for sync_fifo. It pops words through the FIFO pop port (rd_en, registered rd_data, one-cycle latency) and presents them as a valid/ready output stream. It prefetches into a 3-entry output buffer, so it sustains one beat per clock with no combinational path from m_ready_i to fifo_rd_en_o. It never issues a pop on an empty FIFO.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/stream_obuf.sv | 69 ++++++
 rtl/fifo_stream_reader.sv | 81 ++++++++
 tb/tb_fifo_stream_reader.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the FIFO read-side stream master.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int BUF_DEPTH  = 3;
    localparam int PTR_W      = 2;
    localparam int OCC_W      = 2;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [OCC_W-1:0] occ_t;

    // Circular-buffer pointer step; the buffer is three deep, so 2 wraps to 0.
    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

endpackage

// File: rtl/stream_obuf.sv
// Three-entry circular output buffer; head word is always visible on rd_data.
module stream_obuf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output occ_t              occ
);

    logic [DATA_W-1:0] mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] mem_d [BUF_DEPTH];
    ptr_t              head_q, head_d;
    ptr_t              tail_q, tail_d;
    occ_t              occ_q, occ_d;
    logic              do_rd;

    // Next-state for storage, pointers and occupancy; flush wins over everything.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        do_rd  = rd_en && (occ_q != '0);
        if (flush) begin
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[tail_q] = wr_data;
                tail_d        = ptr_inc(tail_q);
            end
            if (do_rd) begin
                head_d = ptr_inc(head_q);
            end
            case ({wr_en, do_rd})
                2'b10:   occ_d = occ_q + occ_t'(1);
                2'b01:   occ_d = occ_q - occ_t'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Register the buffer state; reset clears storage so the head reads as zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q  <= '{default: '0};
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign rd_data = mem_q[head_q];
    assign occ     = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a sync_fifo through its registered read port and re-presents the words
// as a valid/ready stream, prefetching into a three-entry buffer so that pop
// issue depends only on registered state and never on m_ready_i.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              flush_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_rd_data_i,
    input  logic              fifo_empty_i,
    input  logic              fifo_underflow_i,
    output logic              m_valid_o,
    output logic [DATA_W-1:0] m_data_o,
    input  logic              m_ready_i,
    output logic [CNT_W-1:0]  beat_cnt_o,
    output logic              underflow_err_o,
    output logic              busy_o
);

    occ_t             occ;
    logic [2:0]       committed;
    logic             capture;
    logic             pop;
    logic             inflight_q, inflight_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             uflow_q, uflow_d;

    // Words already buffered plus the one arriving; a pop is only issued when
    // there is guaranteed room for its data, so nothing can be dropped.
    assign committed    = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_rd_en_o = !rst_i && !flush_i && enable_i && !fifo_empty_i
                          && (committed < 3'(BUF_DEPTH));

    assign capture   = inflight_q && !flush_i;
    assign m_valid_o = (occ != '0);
    assign pop       = m_valid_o && m_ready_i;
    assign busy_o    = (occ != '0) || inflight_q;

    stream_obuf #(
        .DATA_W (DATA_W)
    ) u_obuf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush   (flush_i),
        .wr_en   (capture),
        .wr_data (fifo_rd_data_i),
        .rd_en   (pop),
        .rd_data (m_data_o),
        .occ     (occ)
    );

    // Next-state for the in-flight flag, beat counter and sticky underflow flag.
    always_comb begin
        inflight_d = fifo_rd_en_o;
        beat_cnt_d = beat_cnt_q + {{(CNT_W-1){1'b0}}, pop};
        uflow_d    = uflow_q || fifo_underflow_i;
    end

    // Control registers; only reset clears the counter and the error flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
            uflow_q    <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
            uflow_q    <= uflow_d;
        end
    end

    assign beat_cnt_o      = beat_cnt_q;
    assign underflow_err_o = uflow_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural sync_fifo read port.
module tb_fifo_stream_reader;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        enable_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        fifo_rd_en_o;
    logic [7:0]  fifo_rd_data_i = 8'h00;
    logic        fifo_empty_i;
    logic        fifo_underflow_i;
    logic        m_valid_o;
    logic [7:0]  m_data_o;
    logic        m_ready_i = 1'b0;
    logic [31:0] beat_cnt_o;
    logic        underflow_err_o;
    logic        busy_o;

    logic [7:0]  fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          uf_seen = 0;
    logic        fifo_uf = 1'b0;
    logic        force_uf = 1'b0;
    logic        fifo_clear = 1'b0;

    int n_vec = 0;
    int n_miss = 0;

    typedef struct {
        logic       en;
        logic       rdy;
        logic       fl;
        logic       exp_rd_en;
        logic       exp_valid;
        logic [7:0] exp_data;
        logic       exp_busy;
        int         exp_beat;
    } vec_t;

    vec_t vecs[$];

    fifo_stream_reader dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .enable_i         (enable_i),
        .flush_i          (flush_i),
        .fifo_rd_en_o     (fifo_rd_en_o),
        .fifo_rd_data_i   (fifo_rd_data_i),
        .fifo_empty_i     (fifo_empty_i),
        .fifo_underflow_i (fifo_underflow_i),
        .m_valid_o        (m_valid_o),
        .m_data_o         (m_data_o),
        .m_ready_i        (m_ready_i),
        .beat_cnt_o       (beat_cnt_o),
        .underflow_err_o  (underflow_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    assign fifo_empty_i     = (rd_ptr == wr_ptr);
    assign fifo_underflow_i = fifo_uf | force_uf;

    // Behavioural FIFO read port: registered data one cycle after a pop.
    always @(posedge clk_i) begin
        fifo_uf <= 1'b0;
        if (fifo_clear) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en_o) begin
            if (rd_ptr != wr_ptr) begin
                fifo_rd_data_i <= fifo_mem[rd_ptr[5:0]];
                rd_ptr         <= rd_ptr + 1;
            end else begin
                fifo_uf <= 1'b1;
                uf_seen <= uf_seen + 1;
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic fl);
        @(negedge clk_i);
        enable_i  = en;
        m_ready_i = rdy;
        flush_i   = fl;
        #1;
    endtask

    task automatic pushWord(input logic [7:0] v);
        fifo_mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic doReset();
        @(negedge clk_i);
        rst_i      = 1'b1;
        fifo_clear = 1'b1;
        enable_i   = 1'b0;
        m_ready_i  = 1'b0;
        flush_i    = 1'b0;
        @(negedge clk_i);
        rst_i      = 1'b0;
        fifo_clear = 1'b0;
        #1;
    endtask

    task automatic addVec(input logic en, input logic rdy, input logic fl, input logic rd,
                          input logic v, input logic [7:0] d, input logic b, input int beat);
        vec_t x;
        x.en = en; x.rdy = rdy; x.fl = fl;
        x.exp_rd_en = rd; x.exp_valid = v; x.exp_data = d; x.exp_busy = b; x.exp_beat = beat;
        vecs.push_back(x);
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].en, vecs[i].rdy, vecs[i].fl);
            checkOutput($sformatf("%s%0d_rd_en", tag, i), 32'(fifo_rd_en_o), 32'(vecs[i].exp_rd_en));
            checkOutput($sformatf("%s%0d_valid", tag, i), 32'(m_valid_o), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                checkOutput($sformatf("%s%0d_data", tag, i), 32'(m_data_o), 32'(vecs[i].exp_data));
            checkOutput($sformatf("%s%0d_busy", tag, i), 32'(busy_o), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("%s%0d_beat", tag, i), beat_cnt_o, 32'(vecs[i].exp_beat));
        end
    endtask

    initial begin
        int   idx;
        int   first_cyc;
        int   last_cyc;
        int   cnt_rd;
        logic found;
        int   exp_w;

        // Reset state.
        doReset();
        checkOutput("rst_valid", 32'(m_valid_o), 32'd0);
        checkOutput("rst_data", 32'(m_data_o), 32'd0);
        checkOutput("rst_beat", beat_cnt_o, 32'd0);
        checkOutput("rst_uf_err", 32'(underflow_err_o), 32'd0);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);

        // Single word: pop at t, capture at t+1, valid at t+2.
        $display("[TB] single word latency");
        pushWord(8'hA5);
        vecs.delete();
        addVec(1, 1, 0, 1, 0, 8'h00, 0, 0);
        addVec(1, 1, 0, 0, 0, 8'h00, 1, 0);
        addVec(1, 1, 0, 0, 1, 8'hA5, 1, 0);
        addVec(1, 1, 0, 0, 0, 8'h00, 0, 1);
        runTable("lat");

        // Back-pressure: buffer fills to three, then drains eight words in order.
        $display("[TB] back-pressure");
        doReset();
        for (int i = 0; i < 8; i++) pushWord(8'(i));
        vecs.delete();
        addVec(1, 0, 0, 1, 0, 8'h00, 0, 0);
        addVec(1, 0, 0, 1, 0, 8'h00, 1, 0);
        addVec(1, 0, 0, 1, 1, 8'h00, 1, 0);
        for (int i = 0; i < 7; i++) addVec(1, 0, 0, 0, 1, 8'h00, 1, 0);
        addVec(1, 1, 0, 0, 1, 8'h00, 1, 0);
        for (int i = 1; i <= 5; i++) addVec(1, 1, 0, 1, 1, 8'(i), 1, i);
        addVec(1, 1, 0, 0, 1, 8'h06, 1, 6);
        addVec(1, 1, 0, 0, 1, 8'h07, 1, 7);
        addVec(1, 1, 0, 0, 0, 8'h00, 0, 8);
        runTable("bp");

        // Streaming: sixteen words on sixteen consecutive cycles.
        $display("[TB] streaming");
        doReset();
        for (int i = 0; i < 16; i++) pushWord(8'(i));
        idx = 0; first_cyc = -1; last_cyc = -1;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1, 1, 0);
            if (m_valid_o) begin
                checkOutput($sformatf("stream_data%0d", idx), 32'(m_data_o), 32'(idx));
                if (first_cyc < 0) first_cyc = c;
                last_cyc = c;
                idx++;
            end
        end
        checkOutput("stream_count", 32'(idx), 32'd16);
        checkOutput("stream_span", 32'(last_cyc - first_cyc), 32'd15);
        checkOutput("stream_beat", beat_cnt_o, 32'd16);
        checkOutput("stream_uf_err", 32'(underflow_err_o), 32'd0);

        // Empty FIFO: no pops for twenty cycles, then one late word.
        $display("[TB] empty fifo");
        doReset();
        cnt_rd = 0;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, 1, 0);
            if (fifo_rd_en_o) cnt_rd++;
        end
        checkOutput("empty_no_pop", 32'(cnt_rd), 32'd0);
        checkOutput("empty_uf_seen", 32'(uf_seen), 32'd0);
        checkOutput("empty_uf_err", 32'(underflow_err_o), 32'd0);
        pushWord(8'h3C);
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            applyStimulus(1, 1, 0);
            if (m_valid_o) begin
                found = 1'b1;
                checkOutput("late_data", 32'(m_data_o), 32'h3C);
            end
        end
        checkOutput("late_found", 32'(found), 32'd1);
        applyStimulus(1, 1, 0);
        checkOutput("late_valid_drop", 32'(m_valid_o), 32'd0);
        checkOutput("late_beat", beat_cnt_o, 32'd1);

        // Flush while word 0x11 is in flight: delivery resumes at 0x12.
        $display("[TB] flush");
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 6; i++) pushWord(8'h10 + 8'(i));
        applyStimulus(1, 0, 0);
        checkOutput("fl_c0_rd_en", 32'(fifo_rd_en_o), 32'd1);
        applyStimulus(1, 0, 0);
        checkOutput("fl_c1_rd_en", 32'(fifo_rd_en_o), 32'd1);
        applyStimulus(1, 0, 1);
        checkOutput("fl_c2_rd_en", 32'(fifo_rd_en_o), 32'd0);
        checkOutput("fl_c2_busy", 32'(busy_o), 32'd1);
        applyStimulus(1, 0, 0);
        checkOutput("fl_after_valid", 32'(m_valid_o), 32'd0);
        checkOutput("fl_after_beat", beat_cnt_o, 32'd1);
        exp_w = 8'h12;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1, 1, 0);
            if (m_valid_o) begin
                checkOutput("fl_resume_data", 32'(m_data_o), 32'(exp_w));
                exp_w++;
            end
        end
        checkOutput("fl_resume_end", 32'(exp_w), 32'h16);
        checkOutput("fl_final_beat", beat_cnt_o, 32'd5);

        // Reset mid-stream.
        $display("[TB] reset mid-stream");
        applyStimulus(0, 0, 0);
        for (int i = 0; i < 8; i++) pushWord(8'h40 + 8'(i));
        for (int c = 0; c < 6; c++) applyStimulus(1, 1, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkOutput("mid_rst_rd_en", 32'(fifo_rd_en_o), 32'd0);
        @(negedge clk_i);
        rst_i    = 1'b0;
        enable_i = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 32'(m_valid_o), 32'd0);
        checkOutput("mid_rst_beat", beat_cnt_o, 32'd0);
        checkOutput("mid_rst_busy", 32'(busy_o), 32'd0);

        // Sticky underflow error.
        $display("[TB] underflow sticky");
        @(negedge clk_i);
        force_uf = 1'b1;
        @(negedge clk_i);
        force_uf = 1'b0;
        #1;
        checkOutput("uf_set", 32'(underflow_err_o), 32'd1);
        for (int c = 0; c < 5; c++) applyStimulus(0, 1, 0);
        checkOutput("uf_hold", 32'(underflow_err_o), 32'd1);
        doReset();
        checkOutput("uf_cleared", 32'(underflow_err_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
